mv_array_reader: RTL
====================

# mv_array_reader

Reads the per-block motion-vector array out in raster order once the motion-estimation controller has finished writing a frame. It streams each vector to the downstream encoder/packer over a valid/ready handshake, tagged with row-last and frame-last markers. It sits on the read port of the MV array RAM, opposite the controller's write port (curpos / MVArray_WE). It uses the same {y,x} block address format as the writer.

## Interface
- TOTAL_BLOCK_X, 79, last block column index (row holds TOTAL_BLOCK_X+1 blocks)
- TOTAL_BLOCK_Y, 44, last block row index
- MV_WIDTH, 16, width of one stored motion vector word
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle pulse: frame in MV array is complete, begin readout
- rd_en  out  1  MV array read strobe
- rd_addr  out  14  {y[6:0], x[6:0]} block address, same packing as the writer's curpos
- rd_data  in  MV_WIDTH  RAM output, valid exactly one cycle after rd_en
- mv_data  out  MV_WIDTH  streamed vector
- mv_valid  out  1  mv_data/flags valid
- mv_ready  in  1  downstream accepts when mv_valid && mv_ready
- mv_rowlast  out  1  vector is column TOTAL_BLOCK_X
- mv_framelast  out  1  vector is (TOTAL_BLOCK_X, TOTAL_BLOCK_Y)
- busy  out  1  readout in progress
- done  out  1  one-cycle pulse after last vector accepted

## Operation
- FSM states: IDLE, READ, DRAIN.
  - IDLE: start → READ; x,y cleared to 0.
  - READ: issues reads. After the read of (TOTAL_BLOCK_X, TOTAL_BLOCK_Y) is issued → DRAIN.
  - DRAIN: waits for the buffer and the in-flight read to empty and the framelast beat to be accepted. Then pulses done and → IDLE.
- start is ignored outside IDLE.
- Address counters are 7 bits each.
  - x increments per issued read. At TOTAL_BLOCK_X, x wraps to 0 and y increments.
  - rd_addr = {y,x} concatenation, not y*(TOTAL_BLOCK_X+1)+x.
- Flags are computed from x,y at issue time and carried with the data through the buffer.
- Buffer: 2-entry FIFO absorbs the 1-cycle RAM latency.
  - Signals: occ = FIFO occupancy; inflight = read issued last cycle; pop = mv_valid && mv_ready.
  - rd_en = (state==READ) && (occ + inflight − pop) < 2.
  - This gives 1 vector/cycle sustained with mv_ready high and no overflow under any backpressure.
- While mv_valid && !mv_ready: mv_data, mv_rowlast and mv_framelast are held stable.
- busy = (state != IDLE).

## Timing
- Reset values: rd_en=0, rd_addr=0, mv_valid=0, mv_data=0, mv_rowlast=0, mv_framelast=0, busy=0, done=0. FSM in IDLE, FIFO empty, inflight=0.
- start sampled high at edge t:
  - busy and first rd_en (addr 0) in cycle t+1.
  - rd_data in t+2, written to FIFO at end of t+2.
  - mv_valid first high in t+3 (start→first valid = 3 cycles).
- With mv_ready held high, vectors are contiguous: the frame's (TOTAL_BLOCK_X+1)(TOTAL_BLOCK_Y+1) beats occupy consecutive cycles.
- done is high in the cycle after the framelast handshake. busy falls in the same cycle as done.
- Reset mid-operation: FSM → IDLE, FIFO flushed, counters cleared. rd_data returning for a read issued in the reset cycle is discarded.
- Simultaneous push and pop on a full FIFO: legal only when occ=2 and pop. The rd_en rule never pushes into a full FIFO without a pop.

## Structure
- Shared package mv_pkg:
  - TOTAL_BLOCK_X, TOTAL_BLOCK_Y, MV_WIDTH.
  - Block address width (14) and {y,x} field widths (7/7).
  - FSM state enum.
  - The controller uses the same constants.
- One sub-module, mv_skid_fifo: 2-entry FIFO of {framelast, rowlast, data}, with push/pop, occ and registered head outputs.

## Test plan
- Full frame, mv_ready=1, RAM preloaded with data=addr:
  - first mv_valid 3 cycles after start, 3600 consecutive beats;
  - mv_rowlast on every 80th beat;
  - mv_framelast on beat 3600 with data {7'd44,7'd79};
  - done one cycle later.
- Backpressure: mv_ready low for 10 cycles mid-row.
  - mv_data and flags stable, rd_en deasserts after ≤2 reads, no beat lost or duplicated.
- Random mv_ready (50%), TOTAL_BLOCK_X=2, TOTAL_BLOCK_Y=1:
  - exactly 6 beats in order 0,1,2,128,129,130 (packed {y,x});
  - rowlast on beats 3 and 6, framelast on beat 6.
- start pulsed again at beat 100: ignored; exactly one frame emitted, one done pulse.
- reset asserted in cycle 50 of readout:
  - all outputs return to reset values next cycle;
  - subsequent start produces a clean frame beginning at addr 0.
- mv_ready low before first valid, raised 5 cycles later: first beat addr 0 accepted, then full-rate streaming.

Source files
------------

// File: rtl/mv_pkg.sv
// Shared constants and types for the motion-vector array path.
// Both the ME controller (write side) and mv_array_reader (read side) pull
// their frame geometry and {y,x} block address packing from here.
package mv_pkg;

  // Frame geometry in blocks: last column/row index, not counts.
  localparam int TOTAL_BLOCK_X = 79;
  localparam int TOTAL_BLOCK_Y = 44;

  // One stored motion-vector word.
  localparam int MV_WIDTH = 16;

  // Block address is {y, x}; each field is 7 bits wide.
  localparam int COORD_WIDTH = 7;
  localparam int ADDR_WIDTH  = 2 * COORD_WIDTH;

  // Depth of the reader's output buffer; two entries cover the RAM latency.
  localparam int FIFO_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } mv_state_t;

  // Packs block coordinates the same way the writer's curpos does.
  function automatic logic [ADDR_WIDTH-1:0] pack_addr(
    input logic [COORD_WIDTH-1:0] y,
    input logic [COORD_WIDTH-1:0] x
  );
    return {y, x};
  endfunction

endpackage

// File: rtl/mv_skid_fifo.sv
// Two-entry FIFO that sits between the MV array RAM read port and the
// valid/ready output stream. The head entry is a register, so the stream
// outputs stay stable while the downstream stalls.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   push        - write push_data this cycle
//   push_data   - entry to write
//   pop         - head consumed this cycle
//   occ         - current number of stored entries (0..FIFO_DEPTH)
//   head        - oldest entry, registered
//   valid       - head holds a stored entry
module mv_skid_fifo
  import mv_pkg::*;
#(
  parameter int WIDTH = MV_WIDTH + 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             push,
  input  logic [WIDTH-1:0]                 push_data,
  input  logic                             pop,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  occ,
  output logic [WIDTH-1:0]                 head,
  output logic                             valid
);

  logic [WIDTH-1:0] tail;

  assign valid = (occ != '0);

  // Entries only ever move from tail to head, so the head register changes
  // exclusively on a pop or on a push into an empty buffer.
  always_ff @(posedge clk) begin
    if (reset) begin
      occ  <= '0;
      head <= '0;
      tail <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ == '0) head <= push_data;
          else           tail <= push_data;
          occ <= occ + 1'b1;
        end
        2'b01: begin
          head <= tail;
          occ  <= occ - 1'b1;
        end
        2'b11: begin
          if (occ == 1) begin
            head <= push_data;
          end else begin
            head <= tail;
            tail <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mv_array_reader.sv
// Streams the motion-vector array out in raster order after the ME
// controller has finished a frame. Reads come from the MV array RAM
// (1-cycle latency) and leave over a valid/ready handshake with row-last
// and frame-last markers attached.
// Ports:
//   clk, reset              - clock, synchronous active-high reset
//   start                   - pulse: frame complete, begin readout (IDLE only)
//   rd_en, rd_addr          - RAM read strobe and {y,x} block address
//   rd_data                 - RAM data, valid one cycle after rd_en
//   mv_data, mv_valid       - output vector and its valid
//   mv_ready                - downstream accept
//   mv_rowlast/framelast    - vector is the last of its row / of the frame
//   busy                    - readout in progress
//   done                    - pulse the cycle after the frame-last handshake
module mv_array_reader
  import mv_pkg::*;
#(
  parameter int TOTAL_BLOCK_X = mv_pkg::TOTAL_BLOCK_X,
  parameter int TOTAL_BLOCK_Y = mv_pkg::TOTAL_BLOCK_Y,
  parameter int MV_WIDTH      = mv_pkg::MV_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [MV_WIDTH-1:0]   rd_data,
  output logic [MV_WIDTH-1:0]   mv_data,
  output logic                  mv_valid,
  input  logic                  mv_ready,
  output logic                  mv_rowlast,
  output logic                  mv_framelast,
  output logic                  busy,
  output logic                  done
);

  localparam logic [COORD_WIDTH-1:0] LAST_X = COORD_WIDTH'(TOTAL_BLOCK_X);
  localparam logic [COORD_WIDTH-1:0] LAST_Y = COORD_WIDTH'(TOTAL_BLOCK_Y);
  localparam int OCC_WIDTH = $clog2(FIFO_DEPTH + 1);

  mv_state_t state, state_next;

  logic [COORD_WIDTH-1:0] x, y;
  logic                   at_row_end, at_frame_end;
  logic                   inflight, inflight_rowlast, inflight_framelast;
  logic [OCC_WIDTH-1:0]   occ;
  logic                   pop;
  logic [2:0]             pending;

  assign pop          = mv_valid && mv_ready;
  assign at_row_end   = (x == LAST_X);
  assign at_frame_end = at_row_end && (y == LAST_Y);
  assign rd_addr      = pack_addr(y, x);
  assign busy         = (state != IDLE);

  // Entries that will be in the buffer after this cycle if no read is issued.
  // A read is only allowed while that leaves room for its data.
  assign pending = 3'(occ) + 3'(inflight) - 3'(pop);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    rd_en      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = READ;
      end
      READ: begin
        rd_en = (pending < 3'(FIFO_DEPTH));
        if (rd_en && at_frame_end) state_next = DRAIN;
      end
      DRAIN: begin
        // The frame-last beat can only reach the head after DRAIN is entered.
        if (pop && mv_framelast) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Raster counters; y returns to 0 after the final block so IDLE starts clean.
  always_ff @(posedge clk) begin
    if (reset || state == IDLE) begin
      x <= '0;
      y <= '0;
    end else if (rd_en) begin
      if (at_row_end) begin
        x <= '0;
        y <= at_frame_end ? '0 : y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

  // Flags travel alongside the outstanding read so they meet rd_data.
  always_ff @(posedge clk) begin
    if (reset) begin
      inflight           <= 1'b0;
      inflight_rowlast   <= 1'b0;
      inflight_framelast <= 1'b0;
    end else begin
      inflight <= rd_en;
      if (rd_en) begin
        inflight_rowlast   <= at_row_end;
        inflight_framelast <= at_frame_end;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) done <= 1'b0;
    else       done <= (state == DRAIN) && pop && mv_framelast;
  end

  mv_skid_fifo #(
    .WIDTH(MV_WIDTH + 2)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (inflight),
    .push_data ({inflight_framelast, inflight_rowlast, rd_data}),
    .pop       (pop),
    .occ       (occ),
    .head      ({mv_framelast, mv_rowlast, mv_data}),
    .valid     (mv_valid)
  );

endmodule
